// File: rtl/cam_table_responder.sv
// Key/value table responder: a fully associative table with one lookup port
// (latency-1 registered responses, 1 request per cycle) and a split update
// port whose index and data channels are paired up by a small FSM before a
// single-cycle commit into the table.
module cam_table_responder #(
    parameter int TABLE_SIZE = 16,
    parameter int KEY_SIZE   = 16,
    parameter int VALUE_SIZE = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [KEY_SIZE-1:0]               s_lookup_req_index,
    input  logic                              s_lookup_req_valid,
    output logic                              s_lookup_req_ready,
    output logic                              s_lookup_value_valid,
    output logic [VALUE_SIZE-1:0]             s_lookup_value_data,
    output logic                              s_lookup_value_hit,
    input  logic                              s_lookup_value_ready,
    input  logic [KEY_SIZE-1:0]               s_update_req_index,
    input  logic                              s_update_req_index_valid,
    output logic                              s_update_req_index_ready,
    input  logic [VALUE_SIZE-1:0]             s_update_req_data,
    input  logic                              s_update_req_data_valid,
    output logic                              s_update_req_data_ready,
    output logic [$clog2(TABLE_SIZE+1)-1:0]   occupancy
);

    localparam int IDX_W = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, HAVE_KEY, HAVE_DATA, COMMIT} state_t;

    // Table storage; entries are flops because every entry is compared in parallel
    logic                  ent_vld   [TABLE_SIZE];
    logic [KEY_SIZE-1:0]   ent_key   [TABLE_SIZE];
    logic [VALUE_SIZE-1:0] ent_value [TABLE_SIZE];

    state_t                state_reg, state_next;
    logic                  key_held_reg, data_held_reg;
    logic [KEY_SIZE-1:0]   key_hold_reg;
    logic [VALUE_SIZE-1:0] data_hold_reg;
    logic [IDX_W-1:0]      victim_reg;
    logic                  ready_en_reg;

    logic                  index_accept, data_accept, req_accept, commit;
    logic                  lk_hit;
    logic [VALUE_SIZE-1:0] lk_value;
    logic                  up_match, free_any;
    logic [IDX_W-1:0]      up_match_idx, free_idx, write_idx;

    assign index_accept = s_update_req_index_valid && s_update_req_index_ready;
    assign data_accept  = s_update_req_data_valid && s_update_req_data_ready;
    assign commit       = (state_reg == COMMIT);

    // Request ready is held low during reset and comes up the first cycle after release
    assign s_lookup_req_ready = ready_en_reg && (!s_lookup_value_valid || s_lookup_value_ready);
    assign req_accept         = s_lookup_req_valid && s_lookup_req_ready;

    // Parallel lookup match against the current (pre-commit) contents
    always_comb begin
        lk_hit   = 1'b0;
        lk_value = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            if (ent_vld[i] && ent_key[i] == s_lookup_req_index) begin
                lk_hit   = 1'b1;
                lk_value = ent_value[i];
            end
        end
    end

    // Commit target: matching entry, else lowest free entry, else the victim
    always_comb begin
        up_match     = 1'b0;
        up_match_idx = '0;
        free_any     = 1'b0;
        free_idx     = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (ent_vld[i] && ent_key[i] == key_hold_reg) begin
                up_match     = 1'b1;
                up_match_idx = IDX_W'(i);
            end
            if (!ent_vld[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        write_idx = up_match ? up_match_idx : (free_any ? free_idx : victim_reg);
    end

    // Per-entry write port, active only in the commit cycle
    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_entry
            // Entry gi captures the held pair when it is the commit target
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ent_vld[gi]   <= 1'b0;
                    ent_key[gi]   <= '0;
                    ent_value[gi] <= '0;
                end else if (commit && write_idx == IDX_W'(gi)) begin
                    ent_vld[gi]   <= 1'b1;
                    ent_key[gi]   <= key_hold_reg;
                    ent_value[gi] <= data_hold_reg;
                end
            end
        end
    endgenerate

    // Occupancy grows only on a fresh insert; a full table advances the victim pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy  <= '0;
            victim_reg <= '0;
        end else if (commit && !up_match) begin
            if (free_any) begin
                occupancy <= occupancy + 1'b1;
            end else begin
                victim_reg <= (victim_reg == IDX_W'(TABLE_SIZE - 1)) ? '0 : victim_reg + 1'b1;
            end
        end
    end

    // Update channel holding registers; both are released by the commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_held_reg  <= 1'b0;
            data_held_reg <= 1'b0;
            key_hold_reg  <= '0;
            data_hold_reg <= '0;
        end else if (commit) begin
            key_held_reg  <= 1'b0;
            data_held_reg <= 1'b0;
        end else begin
            if (index_accept) begin
                key_held_reg <= 1'b1;
                key_hold_reg <= s_update_req_index;
            end
            if (data_accept) begin
                data_held_reg <= 1'b1;
                data_hold_reg <= s_update_req_data;
            end
        end
    end

    // Update FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Update FSM next state: commit once both halves of the pair are captured
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (index_accept && data_accept) state_next = COMMIT;
                else if (index_accept)           state_next = HAVE_KEY;
                else if (data_accept)            state_next = HAVE_DATA;
            end
            HAVE_KEY:  if (data_accept)  state_next = COMMIT;
            HAVE_DATA: if (index_accept) state_next = COMMIT;
            default:   state_next = IDLE;
        endcase
    end

    // Update FSM outputs: each channel is ready while its holding register is empty
    always_comb begin
        s_update_req_index_ready = !key_held_reg && (state_reg != COMMIT);
        s_update_req_data_ready  = !data_held_reg && (state_reg != COMMIT);
    end

    // Registered lookup response; held stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_reg         <= 1'b0;
            s_lookup_value_valid <= 1'b0;
            s_lookup_value_data  <= '0;
            s_lookup_value_hit   <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (req_accept) begin
                s_lookup_value_valid <= 1'b1;
                s_lookup_value_data  <= lk_value;
                s_lookup_value_hit   <= lk_hit;
            end else if (s_lookup_value_ready) begin
                s_lookup_value_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_table_responder.sv
// Directed bench for cam_table_responder: table-driven lookup/update/reset
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_cam_table_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lk_index = '0;
    logic        lk_valid = 1'b0;
    logic        lk_req_ready;
    logic        vv;
    logic [31:0] vdata;
    logic        vhit;
    logic        vready = 1'b1;
    logic [15:0] up_index = '0;
    logic        up_index_valid = 1'b0;
    logic        up_index_ready;
    logic [31:0] up_data = '0;
    logic        up_data_valid = 1'b0;
    logic        up_data_ready;
    logic [4:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int OP_RESET  = 0;
    localparam int OP_LOOKUP = 1;
    localparam int OP_UPDATE = 2;

    typedef struct {
        int          op;
        logic [15:0] key;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_occ;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    cam_table_responder #(.TABLE_SIZE(16), .KEY_SIZE(16), .VALUE_SIZE(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_lookup_req_index       (lk_index),
        .s_lookup_req_valid       (lk_valid),
        .s_lookup_req_ready       (lk_req_ready),
        .s_lookup_value_valid     (vv),
        .s_lookup_value_data      (vdata),
        .s_lookup_value_hit       (vhit),
        .s_lookup_value_ready     (vready),
        .s_update_req_index       (up_index),
        .s_update_req_index_valid (up_index_valid),
        .s_update_req_index_ready (up_index_ready),
        .s_update_req_data        (up_data),
        .s_update_req_data_valid  (up_data_valid),
        .s_update_req_data_ready  (up_data_ready),
        .occupancy                (occupancy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int op, logic [15:0] key, logic [31:0] data,
                                logic exp_hit, logic [31:0] exp_data, int exp_occ);
        vec_t v;
        v.op = op; v.key = key; v.data = data;
        v.exp_hit = exp_hit; v.exp_data = exp_data; v.exp_occ = exp_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(lk_req_ready), 0);
        check("rst_value_valid", 32'(vv), 0);
        check("rst_value_hit", 32'(vhit), 0);
        check("rst_value_data", vdata, 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_index_ready", 32'(up_index_ready), 1);
        check("rst_data_ready", 32'(up_data_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        check("req_ready_before_first_edge", 32'(lk_req_ready), 0);
        @(posedge clk); #1;
        check("req_ready_after_release", 32'(lk_req_ready), 1);
        $display("reset applied and released");
    endtask

    task automatic do_update(input logic [15:0] k, input logic [31:0] d, input int exp_occ);
        @(negedge clk);
        up_index = k; up_data = d;
        up_index_valid = 1'b1; up_data_valid = 1'b1;
        check("upd_index_ready_idle", 32'(up_index_ready), 1);
        check("upd_data_ready_idle", 32'(up_data_ready), 1);
        @(posedge clk); #1;
        up_index_valid = 1'b0; up_data_valid = 1'b0;
        check("commit_index_ready", 32'(up_index_ready), 0);
        check("commit_data_ready", 32'(up_data_ready), 0);
        @(posedge clk); #1;
        check("upd_occupancy", 32'(occupancy), 32'(exp_occ));
        check("post_commit_index_ready", 32'(up_index_ready), 1);
        $display("update key=%0d data=0x%0h occ=%0d (exp %0d)", k, d, occupancy, exp_occ);
    endtask

    task automatic do_lookup(input logic [15:0] k, input logic exp_hit,
                             input logic [31:0] exp_data, input int exp_occ);
        int waited;
        @(negedge clk);
        lk_index = k; lk_valid = 1'b1;
        waited = 0;
        while (!lk_req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("lookup_req_ready", 32'(lk_req_ready), 1);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        check("lookup_value_valid", 32'(vv), 1);
        check("lookup_hit", 32'(vhit), 32'(exp_hit));
        check("lookup_data", vdata, exp_data);
        check("lookup_occupancy", 32'(occupancy), 32'(exp_occ));
        $display("lookup key=%0d hit=%0d data=0x%0h (exp hit=%0d data=0x%0h)",
                 k, vhit, vdata, exp_hit, exp_data);
    endtask

    task automatic run_vec(input vec_t v);
        case (v.op)
            OP_RESET:  do_reset();
            OP_LOOKUP: do_lookup(v.key, v.exp_hit, v.exp_data, v.exp_occ);
            default:   do_update(v.key, v.data, v.exp_occ);
        endcase
    endtask

    initial begin
        // Phase A: basic miss/insert/hit on an empty table
        vecs_a.push_back(mk(OP_RESET,  0, 0, 0, 0, 0));
        vecs_a.push_back(mk(OP_LOOKUP, 4, 0, 0, 0, 0));
        vecs_a.push_back(mk(OP_UPDATE, 10, 32'hDEADBEEF, 0, 0, 1));
        vecs_a.push_back(mk(OP_LOOKUP, 10, 0, 1, 32'hDEADBEEF, 1));

        // Phase B: fill the table, then exercise victim replacement and overwrite
        vecs_b.push_back(mk(OP_RESET, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++)
            vecs_b.push_back(mk(OP_UPDATE, 16'(k), 32'h100 + 32'(k), 0, 0, k + 1));
        vecs_b.push_back(mk(OP_UPDATE, 100, 32'h1, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 0,   0, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 100, 0, 1, 32'h1, 16));
        vecs_b.push_back(mk(OP_UPDATE, 101, 32'h2, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 1,   0, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 101, 0, 1, 32'h2, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 2,   0, 1, 32'h102, 16));
        vecs_b.push_back(mk(OP_UPDATE, 100, 32'h3, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 100, 0, 1, 32'h3, 16));
        vecs_b.push_back(mk(OP_UPDATE, 102, 32'h4, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 2,   0, 0, 0, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 102, 0, 1, 32'h4, 16));
        vecs_b.push_back(mk(OP_LOOKUP, 15,  0, 1, 32'h10F, 16));

        repeat (2) @(posedge clk);
        foreach (vecs_a[i]) run_vec(vecs_a[i]);

        // Data channel arrives three cycles before the key
        @(negedge clk);
        up_data = 32'h55; up_data_valid = 1'b1;
        @(posedge clk); #1;
        up_data_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("have_data_data_ready", 32'(up_data_ready), 0);
            check("have_data_index_ready", 32'(up_index_ready), 1);
        end
        up_index = 7; up_index_valid = 1'b1;
        @(posedge clk); #1;
        up_index_valid = 1'b0;
        check("late_key_commit_index_ready", 32'(up_index_ready), 0);
        @(posedge clk); #1;
        check("late_key_occupancy", 32'(occupancy), 2);
        check("late_key_data_ready", 32'(up_data_ready), 1);
        $display("split update key=7 data=0x55 occ=%0d", occupancy);
        do_lookup(7, 1, 32'h55, 2);
        do_update(7, 32'h66, 2);
        do_lookup(7, 1, 32'h66, 2);

        // Back-to-back lookups with a 3-cycle consumer stall
        do_update(1, 32'h11, 3);
        do_update(2, 32'h22, 4);
        do_update(3, 32'h33, 5);
        vready = 1'b0;
        @(negedge clk);
        lk_index = 1; lk_valid = 1'b1;
        @(posedge clk); #1;
        lk_index = 2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(lk_req_ready), 0);
            check("stall_valid", 32'(vv), 1);
            check("stall_data_k1", vdata, 32'h11);
            check("stall_hit_k1", 32'(vhit), 1);
        end
        vready = 1'b1;
        @(posedge clk); #1;
        lk_index = 3;
        @(negedge clk);
        check("burst_data_k2", vdata, 32'h22);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        @(negedge clk);
        check("burst_data_k3", vdata, 32'h33);
        check("burst_valid_k3", 32'(vv), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("burst_valid_drop", 32'(vv), 0);
        $display("stalled burst keys 1,2,3 delivered");

        // Lookup in the commit cycle sees old contents; next cycle sees new
        @(negedge clk);
        up_index = 20; up_data = 32'h2020;
        up_index_valid = 1'b1; up_data_valid = 1'b1;
        @(posedge clk); #1;
        up_index_valid = 1'b0; up_data_valid = 1'b0;
        lk_index = 20; lk_valid = 1'b1;
        check("rbw_commit_data_ready", 32'(up_data_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rbw_commit_cycle_hit", 32'(vhit), 0);
        check("rbw_commit_cycle_data", vdata, 0);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        @(negedge clk);
        check("rbw_next_cycle_hit", 32'(vhit), 1);
        check("rbw_next_cycle_data", vdata, 32'h2020);
        check("rbw_occupancy", 32'(occupancy), 6);
        $display("read-before-write key=20 checked");

        // Reset while a key is held and a response is pending
        @(negedge clk);
        up_index = 30; up_index_valid = 1'b1;
        vready = 1'b0;
        lk_index = 4; lk_valid = 1'b1;
        @(posedge clk); #1;
        up_index_valid = 1'b0; lk_valid = 1'b0;
        check("have_key_index_ready", 32'(up_index_ready), 0);
        check("pending_valid", 32'(vv), 1);
        rst = 1'b1;
        #1;
        check("midrst_index_ready", 32'(up_index_ready), 1);
        check("midrst_valid", 32'(vv), 0);
        check("midrst_occupancy", 32'(occupancy), 0);
        check("midrst_req_ready", 32'(lk_req_ready), 0);
        vready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset asserted in HAVE_KEY");
        do_lookup(30, 0, 0, 0);
        do_lookup(10, 0, 0, 0);

        foreach (vecs_b[i]) run_vec(vecs_b[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stuck DUT cannot hang the run
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cam_table_responder.md
Name: cam_table_responder

Overview:
Responder end of the table lookup/update protocol. It stores up to TABLE_SIZE key/value entries and answers lookup requests from handler pipelines. It accepts key/value writes on a split update port, with separate index and data channels. It is a single-lookup-port table instance: one lookup client and one update client, with no arbitration.

Parameters:
TABLE_SIZE, 16, number of entries
KEY_SIZE, 16, lookup/update key width
VALUE_SIZE, 32, stored value width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_lookup_req_index  in  KEY_SIZE  lookup key
s_lookup_req_valid  in  1  lookup request valid
s_lookup_req_ready  out  1  lookup request accepted
s_lookup_value_valid  out  1  response valid
s_lookup_value_data  out  VALUE_SIZE  response value, 0 on miss
s_lookup_value_hit  out  1  response hit flag
s_lookup_value_ready  in  1  response consumed
s_update_req_index  in  KEY_SIZE  update key
s_update_req_index_valid  in  1  update key valid
s_update_req_index_ready  out  1  update key accepted
s_update_req_data  in  VALUE_SIZE  update value
s_update_req_data_valid  in  1  update value valid
s_update_req_data_ready  out  1  update value accepted
occupancy  out  $clog2(TABLE_SIZE+1)  count of valid entries

Behaviour:
- Reset state:
  - Clock is clk; reset is rst, asynchronous, active-high.
  - Reset clears all entry valid bits, both held flags, the FSM (to IDLE), the victim pointer and occupancy.
  - All outputs reset to 0, except the two update ready outputs, which reset to 1.
  - s_lookup_req_ready goes to 1 on the first cycle after reset is released.
- Storage: each entry holds {vld, key[KEY_SIZE], value[VALUE_SIZE]}. By construction, at most one valid entry matches a given key.
- Lookup:
  - s_lookup_req_ready = !s_lookup_value_valid || s_lookup_value_ready.
  - A request is accepted when valid && ready.
  - The response is registered the next cycle (latency 1) and supports back-to-back throughput of 1 request per cycle.
  - Hit: data = matching entry's value, hit = 1. Miss: data = 0, hit = 0.
  - Data and hit stay stable while value_valid && !value_ready.
  - value_valid drops on a ready handshake unless a new request is accepted in the same cycle.
- Update channels:
  - Index and data channels are independent; either may arrive first.
  - Each channel captures into its own holding register: index_ready = !key_held, data_ready = !data_held.
- Update FSM:
  - IDLE: key accepted -> HAVE_KEY; data accepted -> HAVE_DATA; both accepted in the same cycle -> COMMIT.
  - HAVE_KEY: data accepted -> COMMIT.
  - HAVE_DATA: key accepted -> COMMIT.
  - COMMIT (one cycle): write the table, clear both held flags -> IDLE. Both ready outputs are 0 during COMMIT.
- Commit rules:
  - Key matches a valid entry: overwrite its value; occupancy unchanged.
  - Else a free entry exists: write the lowest-index free entry, set vld, occupancy +1.
  - Else table full: replace the entry at the victim pointer, then advance the pointer (wraps TABLE_SIZE-1 -> 0); occupancy stays at TABLE_SIZE.
- Lookup/commit in the same cycle: a lookup accepted in the COMMIT cycle sees pre-commit contents (read-before-write). A lookup accepted the cycle after COMMIT sees the new contents.
- Reset mid-operation: a held key/data pair is discarded and a pending response is dropped; no partial table write occurs.

Test Plan:
- Reset, then look up key 4 -> one cycle after accept: value_valid=1, hit=0, data=0; occupancy=0.
- Update key 10, value 0xDEADBEEF, both channels in the same cycle -> COMMIT next cycle, occupancy=1. Then look up key 10 -> hit=1, data=0xDEADBEEF.
- Send data 0x55 three cycles before key 7 -> FSM passes through HAVE_DATA, data_ready=0 while held. After commit, lookup 7 -> 0x55. Update key 7 with 0x66 -> overwrite, occupancy unchanged, lookup returns 0x66.
- Fill all 16 keys (0..15), then update key 100 with 0x1 -> entry 0 replaced, key 0 misses, key 100 hits. Update key 101 -> entry 1 replaced.
- Issue lookups for keys 1, 2, 3 back to back with value_ready held low for 3 cycles -> req_ready=0 during the stall, key 1's response held stable, then three responses delivered in order.
- Lookup key 20 accepted in the COMMIT cycle of key 20 -> hit=0. Lookup of key 20 on the next cycle -> hit=1. Assert rst while in HAVE_KEY -> all outputs reset; after release, lookup of that key misses.
